// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: datapath width, response-owner encodings
// and the full-word byte-enable constant.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    R_NONE = 2'b00,
    R_IF   = 2'b01,
    R_DATA = 2'b10
  } resp_e;

endpackage : rv32_pkg

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of data grants won while a fetch waits; raises force_if
// once the fetch has waited STARVE_LIMIT grants so IF gets the next slot.
module mem_arb_starve_cnt #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  input  logic d_gnt,
  input  logic flush,
  output logic force_if
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset branch is asynchronous to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (if_gnt || !if_req) begin
      starve_cnt <= '0;
    end else if (d_gnt && (starve_cnt < LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign force_if = (starve_cnt == LIMIT) && if_req && !flush;

endmodule : mem_arb_starve_cnt

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store: data
// has priority, a starvation counter guarantees fetch progress.
module mem_arbiter
  import rv32_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            flush_i,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [3:0]      d_be_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            ram_en_o,
  output logic            ram_we_o,
  output logic [3:0]      ram_be_o,
  output logic [XLEN-1:0] ram_addr_o,
  output logic [XLEN-1:0] ram_wdata_o,
  input  logic [XLEN-1:0] ram_rdata_i,
  output logic            hold_flag_o
);

  logic  force_if;
  resp_e resp_q;
  resp_e resp_d;

  mem_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req_i),
    .if_gnt   (if_gnt_o),
    .d_gnt    (d_gnt_o),
    .flush    (flush_i),
    .force_if (force_if)
  );

  // Grants are gated by rst so nothing reaches the RAM while held in reset.
  assign d_gnt_o  = rst && d_req_i && !force_if;
  assign if_gnt_o = rst && if_req_i && !flush_i && !d_gnt_o;

  assign ram_en_o    = if_gnt_o || d_gnt_o;
  assign ram_we_o    = d_gnt_o && d_we_i;
  assign ram_be_o    = ram_we_o ? d_be_i : BE_ALL;
  assign ram_addr_o  = d_gnt_o ? d_addr_i : if_addr_i;
  assign ram_wdata_o = d_wdata_i;

  assign hold_flag_o = rst && ((d_req_i && !d_gnt_o) ||
                               (if_req_i && !if_gnt_o && !flush_i));

  // NOTE: resp_d gets a default first, so no path leaves it unassigned and
  // no latch is inferred.
  always_comb begin
    resp_d = R_NONE;
    if (if_gnt_o) begin
      resp_d = R_IF;
    end else if (d_gnt_o && !d_we_i) begin
      resp_d = R_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_q <= R_NONE;
    end else begin
      resp_q <= resp_d;
    end
  end

  // A flush kills the fetch response arriving this cycle; loads are untouched.
  assign if_rvalid_o = (resp_q == R_IF) && !flush_i;
  assign d_rvalid_o  = (resp_q == R_DATA);
  assign if_rdata_o  = {XLEN{if_rvalid_o}} & ram_rdata_i;
  assign d_rdata_o   = {XLEN{d_rvalid_o}} & ram_rdata_i;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, compared against a word-level reference model of the arbiter.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        flush_i;
  logic        d_req_i, d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        ram_en_o, ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [31:0] ram_rdata_i = '0;
  logic        hold_flag_o;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .flush_i(flush_i),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
    .ram_be_o(ram_be_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i), .hold_flag_o(hold_flag_o)
  );

  // Behavioural synchronous-read RAM driven only by the DUT's ram_* outputs.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) ram[ram_addr_o[11:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata_i <= ram[ram_addr_o[11:2]];
      end
    end
  end

  // Reference model: shadow memory, count of data wins since the fetch last
  // got a slot, and who (if anyone) is owed read data next cycle.
  logic [31:0] ref_mem [0:1023];
  int          streak;
  int          pend;        // 0 none, 1 fetch, 2 load
  logic [31:0] pend_data;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One clock cycle: drive at posedge+1, compare before the next edge,
  // then advance the model across the edge.
  task automatic cycle(input logic ifr, input logic [31:0] ia, input logic fl,
                       input logic dr, input logic dwe, input logic [3:0] dbe,
                       input logic [31:0] da, input logic [31:0] dwd);
    logic e_dg, e_ig, e_hold, e_irv, e_drv, if_turn;
    if_req_i = ifr; if_addr_i = ia; flush_i = fl;
    d_req_i = dr; d_we_i = dwe; d_be_i = dbe; d_addr_i = da; d_wdata_i = dwd;
    #3;
    if_turn = (streak >= LIMIT) && ifr && !fl;
    e_dg    = dr && !if_turn;
    e_ig    = ifr && !fl && !e_dg;
    e_hold  = (dr && !e_dg) || (ifr && !e_ig && !fl);
    e_irv   = (pend == 1) && !fl;
    e_drv   = (pend == 2);
    check("if_gnt", 32'(if_gnt_o), 32'(e_ig));
    check("d_gnt", 32'(d_gnt_o), 32'(e_dg));
    check("hold", 32'(hold_flag_o), 32'(e_hold));
    check("ram_en", 32'(ram_en_o), 32'(e_ig || e_dg));
    check("ram_we", 32'(ram_we_o), 32'(e_dg && dwe));
    check("if_rvalid", 32'(if_rvalid_o), 32'(e_irv));
    check("if_rdata", if_rdata_o, e_irv ? pend_data : 32'h0);
    check("d_rvalid", 32'(d_rvalid_o), 32'(e_drv));
    check("d_rdata", d_rdata_o, e_drv ? pend_data : 32'h0);
    if (e_dg || e_ig) check("ram_addr", ram_addr_o, e_dg ? da : ia);
    if (e_dg && !dwe) check("ram_be_rd", 32'(ram_be_o), 32'hF);
    if (e_dg && dwe) begin
      check("ram_be_wr", 32'(ram_be_o), 32'(dbe));
      check("ram_wdata", ram_wdata_o, dwd);
    end
    @(posedge clk); #1;
    if (e_ig || !ifr) streak = 0;
    else if (e_dg && streak < LIMIT) streak++;
    pend = 0;
    if (e_ig) begin
      pend = 1; pend_data = ref_mem[ia[11:2]];
    end else if (e_dg && !dwe) begin
      pend = 2; pend_data = ref_mem[da[11:2]];
    end else if (e_dg && dwe) begin
      ref_mem[da[11:2]] = merge(ref_mem[da[11:2]], dwd, dbe);
    end
  endtask

  // Hold reset low for one cycle with both requesters active.
  task automatic reset_cycle();
    rst = 1'b0;
    if_req_i = 1'b1; d_req_i = 1'b1; d_we_i = 1'b0; flush_i = 1'b0;
    #3;
    check("rst_if_gnt", 32'(if_gnt_o), 32'h0);
    check("rst_d_gnt", 32'(d_gnt_o), 32'h0);
    check("rst_if_rvalid", 32'(if_rvalid_o), 32'h0);
    check("rst_d_rvalid", 32'(d_rvalid_o), 32'h0);
    check("rst_ram_en", 32'(ram_en_o), 32'h0);
    check("rst_ram_we", 32'(ram_we_o), 32'h0);
    check("rst_hold", 32'(hold_flag_o), 32'h0);
    check("rst_if_rdata", if_rdata_o, 32'h0);
    check("rst_d_rdata", d_rdata_o, 32'h0);
    @(posedge clk); #1;
    streak = 0; pend = 0;
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 1023)) << 2;
  endfunction

  initial begin
    logic [31:0] st_data;
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 32'(i) * 32'h0101_0101 ^ 32'hA5C3_0F00;
      ref_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5C3_0F00;
    end
    ram[12'h100 >> 2] = 32'hDEAD_BEEF; ref_mem[12'h100 >> 2] = 32'hDEAD_BEEF;
    ram[12'h200 >> 2] = 32'hFFFF_FFFF; ref_mem[12'h200 >> 2] = 32'hFFFF_FFFF;
    streak = 0; pend = 0; pend_data = '0;
    if_addr_i = '0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
    #1;
    reset_cycle();

    // Fetch only, three consecutive words.
    cycle(1, 32'h0, 0, 0, 0, 4'h0, 0, 0);
    cycle(1, 32'h4, 0, 0, 0, 4'h0, 0, 0);
    cycle(1, 32'h8, 0, 0, 0, 4'h0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 4'h0, 0, 0);

    // Conflict: load wins, fetch granted next cycle.
    cycle(1, 32'hC, 0, 1, 0, 4'h0, 32'h100, 0);
    check("conflict_rdata", d_rdata_o, 32'hDEAD_BEEF);
    cycle(1, 32'hC, 0, 0, 0, 4'h0, 0, 0);

    // Starvation: both requesting continuously.
    for (int i = 0; i < 12; i++)
      cycle(1, 32'h10, 0, 1, 0, 4'h0, rand_addr(), 0);
    cycle(0, 32'h0, 0, 0, 0, 4'h0, 0, 0);

    // Store half-word over all-ones, then read it back.
    cycle(0, 32'h0, 0, 1, 1, 4'b0011, 32'h200, 32'h1234_5678);
    cycle(0, 32'h0, 0, 1, 0, 4'h0, 32'h200, 0);
    st_data = d_rdata_o;
    cycle(0, 32'h0, 0, 0, 0, 4'h0, 0, 0);
    check("store_readback", st_data, 32'hFFFF_5678);

    // Flush the cycle after a fetch grant, with a concurrent load.
    cycle(1, 32'h20, 0, 0, 0, 4'h0, 0, 0);
    cycle(1, 32'h24, 1, 1, 0, 4'h0, 32'h100, 0);
    cycle(0, 32'h0, 0, 0, 0, 4'h0, 0, 0);

    // Reset with a load in flight, then a fetch right after release.
    cycle(0, 32'h0, 0, 1, 0, 4'h0, 32'h100, 0);
    reset_cycle();
    cycle(1, 32'h30, 0, 0, 0, 4'h0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 4'h0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), rand_addr(), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 3),
            4'($urandom_range(0, 15)), rand_addr(), $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_arbiter
